gcd_arbiter: RTL
================

# gcd_arbiter

Round-robin scheduler that shares one GCD engine (start/done handshake, subtract-based datapath plus controller) among N requesters. Each requester presents an operand pair and holds a request line. The arbiter grants one requester, launches the engine, waits for done or a timeout, and returns the result with a one-cycle acknowledge. Zero operands are resolved locally, because the subtract engine never terminates on them.

## Interface
- N, 4, number of requesters (2..8)
- W, 16, operand/result width
- TIMEOUT, 1023, max WAIT cycles before abort (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N  per-requester request, level, held until ack
- op_a  in  N*W  packed operand A, slice k = op_a[k*W +: W]
- op_b  in  N*W  packed operand B, same packing
- ack  out  N  one-hot, one-cycle pulse; result/err valid in that cycle
- result  out  W  GCD of granted pair; 0 on error
- err  out  1  timeout flag, valid with ack
- busy  out  1  high in any state except IDLE
- grant_id  out  clog2(N)  index of current/last granted requester
- gcd_start  out  1  one-cycle engine launch pulse
- gcd_a, gcd_b  out  W  operands to engine, stable from launch until next grant
- gcd_done  in  1  engine completion, sampled only in WAIT
- gcd_result  in  W  engine result, valid with gcd_done

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if any req bit is high, select the first set bit searching upward from pointer p (mod N). Latch grant_id, gcd_a=op_a slice, gcd_b=op_b slice. Go to LAUNCH.
- LAUNCH: if gcd_a==0 or gcd_b==0, latch result=gcd_a|gcd_b, err=0, go to RESP with no gcd_start. Otherwise assert gcd_start (Moore, this cycle only), clear timer, go to WAIT.
- WAIT: timer increments each cycle.
  - gcd_done high: latch result=gcd_result, err=0, go to RESP.
  - Else if timer==TIMEOUT-1: latch result=0, err=1, go to RESP.
  - gcd_done wins when both occur in the same cycle.
- RESP: ack[grant_id]=1 for exactly one cycle. Set p=(grant_id+1) mod N. Go to IDLE.
- Requester must drop req by the first IDLE cycle after its ack. A req still high there is a new request.
- op_a/op_b are sampled only on the IDLE→LAUNCH edge. Later changes are ignored for the current job.
- gcd_done is ignored outside WAIT, so a stray done after an abort or reset has no effect.
- After a timeout the engine is treated as free. The next grant issues gcd_start normally.
- Req bits of non-granted requesters are never dropped; they are served in rotation order.

## Timing
- Reset values (immediate, asynchronous): state IDLE, p=0, ack=0, result=0, err=0, busy=0, grant_id=0, gcd_start=0, gcd_a=0, gcd_b=0, timer=0.
- Engine path: req sampled at edge E0 → LAUNCH in cycle 1 (gcd_start high) → WAIT from cycle 2. gcd_done sampled at edge Ek → ack in the following cycle. Total = engine latency + 3 cycles.
- Zero path: req at E0 → LAUNCH in cycle 1 → ack in cycle 2.
- Timeout path: ack falls TIMEOUT+2 cycles after the req edge.
- Back-to-back: minimum 4 cycles per engine job (IDLE, LAUNCH, WAIT≥1, RESP) and 3 per zero job.
- busy rises the cycle after the grant edge and falls in the IDLE cycle after RESP.
- Reset asserted mid-job: no ack for the aborted job. After rst_n rises, pending reqs are re-arbitrated from p=0.

## Test plan
- req[0], op 143/78; engine model returns 13 five cycles after start → one gcd_start pulse with gcd_a=143, gcd_b=78; ack=0001, result=13, err=0; total 8 cycles.
- All four reqs high from reset with distinct pairs → acks in order 0,1,2,3. Then raise req[1] and req[3] together → req[1] is served first (p=0 search finds 1).
- req[2], op 0/48 → no gcd_start; ack=0100, result=48, two cycles after the grant edge. Then op 0/0 → result=0, err=0.
- Engine never asserts done, TIMEOUT=1023 → ack with err=1, result=0 after 1023 WAIT cycles. Next req with 143/78 completes normally with result 13.
- gcd_done arrives in the same cycle as the timeout → result=gcd_result, err=0.
- rst_n pulsed low in WAIT → all outputs read reset values immediately; late gcd_done produces no ack; held req[1] is re-granted after release.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin front end for one shared subtract-based GCD engine.
// Requesters hold req with an operand pair; one is granted at a time, the
// engine is launched (or the job is finished locally when an operand is zero,
// since the subtract engine would never terminate on it), and the result is
// returned with a one-cycle one-hot ack. A WAIT timer aborts a hung engine.
//
// Handshake: req[k] is a level held until ack[k] pulses for one cycle; result
// and err are valid in that ack cycle, and req[k] must be low by the next IDLE
// cycle or it counts as a new request. gcd_start is a one-cycle launch pulse;
// gcd_done/gcd_result are only looked at while in WAIT.
module gcd_arbiter #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 1023,
    localparam int GW     = (N > 1) ? $clog2(N) : 1,
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  op_a,
    input  logic [N*W-1:0]  op_b,
    output logic [N-1:0]    ack,
    output logic [W-1:0]    result,
    output logic            err,
    output logic            busy,
    output logic [GW-1:0]   grant_id,
    output logic            gcd_start,
    output logic [W-1:0]    gcd_a,
    output logic [W-1:0]    gcd_b,
    input  logic            gcd_done,
    input  logic [W-1:0]    gcd_result,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  p_q, p_d;
    logic [GW-1:0]  grant_id_q, grant_id_d;
    logic [W-1:0]   gcd_a_q, gcd_a_d;
    logic [W-1:0]   gcd_b_q, gcd_b_d;
    logic [W-1:0]   result_q, result_d;
    logic           err_q, err_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic           req_found;
    logic [GW-1:0]  req_sel;
    logic           zero_job;

    // Pick the first pending request at or above the rotation pointer, wrapping.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        for (int i = 0; i < N; i++) begin
            if (!req_found && req[(int'(p_q) + i) % N]) begin
                req_found = 1'b1;
                req_sel   = GW'((int'(p_q) + i) % N);
            end
        end
    end

    assign zero_job = (gcd_a_q == '0) || (gcd_b_q == '0);

    // Next-state and datapath latch decisions for the grant/launch/wait/respond cycle.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        grant_id_d = grant_id_q;
        gcd_a_d    = gcd_a_q;
        gcd_b_d    = gcd_b_q;
        result_d   = result_q;
        err_d      = err_q;
        timer_d    = timer_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_id_d = req_sel;
                    gcd_a_d    = op_a[int'(req_sel)*W +: W];
                    gcd_b_d    = op_b[int'(req_sel)*W +: W];
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                if (zero_job) begin
                    // gcd(x,0) = x and gcd(0,0) is reported as 0.
                    result_d = gcd_a_q | gcd_b_q;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // A done arriving in the timeout cycle still counts as success.
                if (gcd_done) begin
                    result_d = gcd_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                p_d     = (grant_id_q == GW'(N - 1)) ? '0 : grant_id_q + GW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            p_q        <= '0;
            grant_id_q <= '0;
            gcd_a_q    <= '0;
            gcd_b_q    <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            grant_id_q <= grant_id_d;
            gcd_a_q    <= gcd_a_d;
            gcd_b_q    <= gcd_b_d;
            result_q   <= result_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
        end
    end

    assign ack       = (state_q == RESP) ? (N'(1) << grant_id_q) : '0;
    assign gcd_start = (state_q == LAUNCH) && !zero_job;
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign err       = err_q;
    assign grant_id  = grant_id_q;
    assign gcd_a     = gcd_a_q;
    assign gcd_b     = gcd_b_q;
    assign dbg_state = state_q;

endmodule
